// File: rtl/signed_calc_sequencer.sv
// signed_calc_sequencer
//   One-at-a-time operation sequencer for the sign-magnitude calculator
//   datapath. Operands and opcode are captured on acceptance. The operation
//   then runs to completion: add/sub in a single cycle, mul by shift-add,
//   div/rem by restoring division. The result is held until the consumer
//   takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only)
//   op         000 add, 001 sub, 010 mul, 011 div, 100 rem, others illegal
//   a, b       sign-magnitude operands, sign in the MSB
//   out_valid  result valid
//   out_ready  consumer takes the result
//   result     sign-magnitude result, sign in the MSB
//   err        divide-by-zero or illegal opcode, qualified by out_valid
//   busy       operation in flight (EXEC or DONE)
//
// State | meaning
//   IDLE | waiting for a request, in_ready=1
//   EXEC | counter running, one mul/div step per cycle (add/sub: one cycle)
//   DONE | result/err frozen; out_valid rises one cycle after entry and
//        | drops once out_ready is seen with out_valid high

module signed_calc_sequencer #(
  parameter  int MAG_W = 2,
  localparam int RES_W = 2*MAG_W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int ACC_W = 2*MAG_W;
  localparam int CNT_W = $clog2(MAG_W) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [ACC_W-1:0]   opa_q, opa_d;
  logic [ACC_W-1:0]   opb_q, opb_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [MAG_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;

  // Datapath step values
  logic [ACC_W-1:0]   mul_acc;
  logic [ACC_W-1:0]   div_trial;
  logic               div_fit;
  logic [ACC_W-1:0]   div_rem;
  logic [MAG_W-1:0]   div_quo;
  logic               sb_eff;
  logic [ACC_W-1:0]   as_mag;
  logic               as_sign;
  logic [ACC_W-1:0]   fin_mag;
  logic               fin_sign;
  logic [RES_W-1:0]   fin_result;

  logic               op_illegal;
  logic               div_by_zero;

  assign op_illegal  = (op > OP_REM);
  assign div_by_zero = ((op == OP_DIV) || (op == OP_REM)) && (a[MAG_W] | 1'b1)
                       && (b[MAG_W-1:0] == '0);

  always_comb begin
    // Shift-add: opa holds the multiplicand shifted left, opb the multiplier
    // shifted right, so bit 0 of opb selects the current partial product.
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);

    // Restoring division, MSB first: opa is shifted left so its bit MAG_W-1
    // is always the next dividend bit; acc holds the partial remainder.
    div_trial = {acc_q[ACC_W-2:0], opa_q[MAG_W-1]};
    div_fit   = (div_trial >= opb_q);
    div_rem   = div_fit ? (div_trial - opb_q) : div_trial;
    div_quo   = MAG_W'({quo_q, div_fit});

    // Sign-magnitude add; sub is add with b's sign flipped.
    sb_eff = sb_q ^ (op_q == OP_SUB);
    if (sa_q == sb_eff) begin
      as_mag  = opa_q + opb_q;
      as_sign = sa_q;
    end else if (opa_q >= opb_q) begin
      as_mag  = opa_q - opb_q;
      as_sign = sa_q;
    end else begin
      as_mag  = opb_q - opa_q;
      as_sign = sb_eff;
    end

    // Final value as it will look after this cycle's step.
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_mag  = as_mag;
        fin_sign = as_sign;
      end
      OP_MUL: begin
        fin_mag  = mul_acc;
        fin_sign = sa_q ^ sb_q;
      end
      OP_DIV: begin
        fin_mag  = ACC_W'(div_quo);
        fin_sign = sa_q ^ sb_q;
      end
      default: begin
        fin_mag  = div_rem;
        fin_sign = sa_q;
      end
    endcase

    // A zero magnitude is always reported as +0.
    fin_result = {fin_sign && (fin_mag != '0), fin_mag};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          sa_d  = a[MAG_W];
          sb_d  = b[MAG_W];
          opa_d = ACC_W'(a[MAG_W-1:0]);
          opb_d = ACC_W'(b[MAG_W-1:0]);
          acc_d = '0;
          quo_d = '0;
          if (op_illegal || div_by_zero) begin
            state_d  = DONE;
            result_d = '0;
            err_d    = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = EXEC;
            cnt_d   = ((op == OP_ADD) || (op == OP_SUB)) ? CNT_W'(1) : CNT_W'(MAG_W);
          end
        end
      end

      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else if ((op_q == OP_DIV) || (op_q == OP_REM)) begin
          acc_d = div_rem;
          quo_d = div_quo;
          opa_d = opa_q << 1;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = fin_result;
          err_d    = 1'b0;
        end
      end

      DONE: begin
        // out_ready only counts once out_valid is already visible, so the
        // result is always presented for at least one cycle.
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_signed_calc_sequencer.sv
// Directed-vector bench for signed_calc_sequencer (MAG_W=2).
module tb_signed_calc_sequencer;

  localparam int MAG_W = 2;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [2:0] a;
  logic [2:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] result;
  logic       err;
  logic       busy;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  signed_calc_sequencer #(.MAG_W(MAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [4:0] res;
    logic       e;
    int         lat;
    string      name;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Independent integer model: signed values, then back to sign-magnitude.
  function automatic void model(input logic [2:0] o, input logic [2:0] aa, input logic [2:0] bb,
                                output logic [4:0] r, output logic e, output int lat);
    int ma, mb, va, vb, v, m;
    ma = int'(aa[1:0]);
    mb = int'(bb[1:0]);
    va = aa[2] ? -ma : ma;
    vb = bb[2] ? -mb : mb;
    r = '0;
    e = 1'b0;
    v = 0;
    if (o > 3'd4 || ((o == OP_DIV || o == OP_REM) && mb == 0)) begin
      e = 1'b1;
      lat = 1;
      return;
    end
    lat = (o == OP_ADD || o == OP_SUB) ? 2 : 1 + MAG_W;
    case (o)
      OP_ADD: v = va + vb;
      OP_SUB: v = va - vb;
      OP_MUL: v = (aa[2] ^ bb[2]) ? -(ma * mb) : ma * mb;
      OP_DIV: v = (aa[2] ^ bb[2]) ? -(ma / mb) : ma / mb;
      default: v = aa[2] ? -(ma % mb) : ma % mb;
    endcase
    m = (v < 0) ? -v : v;
    r = {v < 0, m[3:0]};
  endfunction

  // Caller is at a negedge with the DUT idle and out_ready=1; returns at the
  // negedge after the result was consumed, ready for the next request.
  task automatic do_op(input logic [2:0] o, input logic [2:0] aa, input logic [2:0] bb,
                       output logic [4:0] r, output logic e, output int lat);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    check("in_ready_before_req", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    e = err;
    @(negedge clk);
    check("single_out", out_valid, 0);
  endtask

  task automatic run_vec(input logic [2:0] o, input logic [2:0] aa, input logic [2:0] bb,
                         input logic [4:0] er, input logic ee, input int el, input string nm);
    logic [4:0] r;
    logic e;
    int lat;
    do_op(o, aa, bb, r, e, lat);
    n_vec++;
    check($sformatf("%s result", nm), r, er);
    check($sformatf("%s err", nm), e, ee);
    check($sformatf("%s latency", nm), lat, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] er;
    logic ee;
    int el;
    int lat;

    vt[0]  = '{OP_SUB, 3'b001, 3'b001, 5'b00000, 1'b0, 2, "sub_equal"};
    vt[1]  = '{OP_MUL, 3'b110, 3'b011, 5'b10110, 1'b0, 3, "mul_neg6"};
    vt[2]  = '{OP_DIV, 3'b111, 3'b010, 5'b10001, 1'b0, 3, "div_m3_2"};
    vt[3]  = '{OP_REM, 3'b111, 3'b010, 5'b10001, 1'b0, 3, "rem_m3_2"};
    vt[4]  = '{OP_REM, 3'b110, 3'b001, 5'b00000, 1'b0, 3, "rem_m2_1"};
    vt[5]  = '{OP_DIV, 3'b011, 3'b100, 5'b00000, 1'b1, 1, "div_by_m0"};
    vt[6]  = '{3'b111, 3'b011, 3'b001, 5'b00000, 1'b1, 1, "op_111"};
    vt[7]  = '{OP_ADD, 3'b101, 3'b001, 5'b00000, 1'b0, 2, "add_cancel"};
    vt[8]  = '{OP_SUB, 3'b010, 3'b011, 5'b10001, 1'b0, 2, "sub_2_3"};
    vt[9]  = '{OP_MUL, 3'b111, 3'b111, 5'b01001, 1'b0, 3, "mul_m3_m3"};
    vt[10] = '{OP_DIV, 3'b011, 3'b110, 5'b10001, 1'b0, 3, "div_3_m2"};
    vt[11] = '{OP_REM, 3'b011, 3'b110, 5'b00001, 1'b0, 3, "rem_3_m2"};
    vt[12] = '{OP_ADD, 3'b111, 3'b111, 5'b10110, 1'b0, 2, "add_m3_m3"};
    vt[13] = '{3'b101, 3'b001, 3'b001, 5'b00000, 1'b1, 1, "op_101"};
    vt[14] = '{OP_MUL, 3'b100, 3'b011, 5'b00000, 1'b0, 3, "mul_m0"};
    vt[15] = '{OP_DIV, 3'b101, 3'b011, 5'b00000, 1'b0, 3, "div_m1_3"};

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset err", err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Get a nonzero result into the register before the abort test.
    run_vec(OP_MUL, 3'b011, 3'b010, 5'b00110, 1'b0, 3, "mul_3_2");

    // Reset mid-operation
    op = OP_MUL; a = 3'b011; b = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    check("abort busy_before_rst", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort result", result, 0);
    check("abort busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort no_output", out_valid, 0);
    end
    run_vec(OP_ADD, 3'b011, 3'b110, 5'b00001, 1'b0, 2, "add_after_abort");

    for (int i = 0; i < 16; i++)
      run_vec(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].e, vt[i].lat, vt[i].name);

    // Backpressure: result held while out_ready is low, extra request ignored
    out_ready = 1'b0;
    op = OP_MUL; a = 3'b011; b = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    check("bp latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp result", result, 5'b01001);
      check("bp err", err, 0);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      in_valid = 1'b1; op = OP_ADD; a = 3'b001; b = 3'b001;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp still_valid", out_valid, 1);
    @(negedge clk);
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    check("bp release busy", busy, 0);
    check("bp result kept", result, 5'b01001);
    @(negedge clk);
    check("bp extra_ignored", out_valid, 0);
    check("bp extra_ignored busy", busy, 0);

    // Exhaustive legal-op sweep, back to back
    for (int o = 0; o < 5; o++)
      for (int ia = 0; ia < 8; ia++)
        for (int ib = 0; ib < 8; ib++) begin
          model(3'(o), 3'(ia), 3'(ib), er, ee, el);
          run_vec(3'(o), 3'(ia), 3'(ib), er, ee, el,
                  $sformatf("sweep op%0d a%0d b%0d", o, ia, ib));
        end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
